wb_prog_loader: RTL



---
 rtl/wb_prog_loader_if.sv | 29 ++
 rtl/wb_prog_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wb_prog_loader_if.sv
// wb_prog_loader_if
//   Wishbone classic slave-port bundle used by wb_prog_loader. The signal
//   names match the user-project wrapper so the wrapper can connect them
//   one-to-one. The _i/_o suffixes are from the responder's point of view.
//
//   wbs_stb_i, wbs_cyc_i, wbs_we_i : strobe, cycle, write enable
//   wbs_sel_i                      : byte selects (responder ignores them)
//   wbs_adr_i, wbs_dat_i           : byte address, write data
//   wbs_ack_o, wbs_dat_o           : single-cycle acknowledge, read data
interface wb_prog_loader_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_prog_loader.sv
// wb_prog_loader
//   Wishbone responder that loads a program into an instruction memory.
//   Words written to DATA are queued in a FIFO. The FIFO drains to the
//   instruction-memory write port with a we/ready handshake while CTRL.hold
//   keeps the core in reset.
//
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   wbs                : Wishbone slave port (wb_prog_loader_if.slave)
//   core_rst_o         : core reset, equal to CTRL.hold
//   imem_we_o          : write request, held until imem_ready_i
//   imem_addr_o        : word address (the load pointer)
//   imem_wdata_o       : write data
//   imem_ready_i       : memory accepts the write when both we and ready are 1
//
//   Registers: 0x0 CTRL{flush,hold}, 0x4 ADDR, 0x8 DATA (write-only),
//              0xC STATUS{addr_err,ovf,count[15:8],full,empty}
module wb_prog_loader #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          IMEM_AW    = 10
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  wb_prog_loader_if.slave    wbs,
  output logic               core_rst_o,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [31:0]        imem_wdata_o,
  input  logic               imem_ready_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Bus-side state. The request is latched when it is accepted. Its side
  // effects are applied from these copies during the ack cycle.
  logic              ack_q;
  logic [31:0]       dat_q;
  logic              req_we_q;
  logic [1:0]        req_reg_q;
  logic [31:0]       req_dat_q;

  // Control/status state
  logic              hold_q;
  logic              ovf_q;
  logic              aerr_q;
  logic [IMEM_AW-1:0] ptr_q, ptr_d;

  // FIFO and output port state
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     count_q, count_d;
  logic              we_q;
  logic [31:0]       wdata_q;

  logic        hit, access;
  logic        ctrl_wr, addr_wr, data_wr, stat_wr, flush;
  logic        fifo_empty, fifo_full, handshake, push, pop, addr_ok;
  logic [7:0]  count8;
  logic [31:0] rdata;
  logic        unused_bits;

  assign hit    = (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  // No new access is accepted while ack is high, so each access takes two cycles.
  assign access = wbs.wbs_stb_i & wbs.wbs_cyc_i & hit & ~ack_q;

  assign ctrl_wr = ack_q & req_we_q & (req_reg_q == 2'd0);
  assign addr_wr = ack_q & req_we_q & (req_reg_q == 2'd1);
  assign data_wr = ack_q & req_we_q & (req_reg_q == 2'd2);
  assign stat_wr = ack_q & req_we_q & (req_reg_q == 2'd3);
  assign flush   = ctrl_wr & req_dat_q[1];

  assign fifo_empty = (count_q == '0);
  // Full uses the count before this cycle. A same-cycle pop does not free a slot for the push.
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign handshake  = we_q & imem_ready_i;
  assign push       = data_wr & ~fifo_full;
  // Start a new write when the port is idle or is freed this cycle. Flush overrides this.
  assign pop        = ~flush & hold_q & ~fifo_empty & (~we_q | handshake);
  assign addr_ok    = fifo_empty & ~we_q;
  assign count8     = 8'(count_q);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A flushed in-flight write does not advance the pointer.
  always_comb begin
    ptr_d = ptr_q;
    if (addr_wr && addr_ok)
      ptr_d = req_dat_q[IMEM_AW-1:0];
    else if (handshake && !flush)
      ptr_d = ptr_q + IMEM_AW'(1);
  end

  always_comb begin
    rdata = '0;
    case (wbs.wbs_adr_i[3:2])
      2'd0:    rdata[0] = hold_q;
      2'd1:    rdata[IMEM_AW-1:0] = ptr_q;
      2'd2:    rdata = '0;
      default: begin
        rdata[0]     = fifo_empty;
        rdata[1]     = fifo_full;
        rdata[15:8]  = count8;
        rdata[16]    = ovf_q;
        rdata[17]    = aerr_q;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      req_we_q  <= 1'b0;
      req_reg_q <= '0;
      req_dat_q <= '0;
      hold_q    <= 1'b1;
      ovf_q     <= 1'b0;
      aerr_q    <= 1'b0;
      ptr_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
    end else begin
      ack_q <= access;
      dat_q <= (access && !wbs.wbs_we_i) ? rdata : '0;
      if (access) begin
        req_we_q  <= wbs.wbs_we_i;
        req_reg_q <= wbs.wbs_adr_i[3:2];
        req_dat_q <= wbs.wbs_dat_i;
      end

      if (ctrl_wr)
        hold_q <= req_dat_q[0];

      ptr_q <= ptr_d;
      if (addr_wr && !addr_ok)
        aerr_q <= 1'b1;
      else if (stat_wr && req_dat_q[17])
        aerr_q <= 1'b0;

      if (data_wr && fifo_full)
        ovf_q <= 1'b1;
      else if (stat_wr && req_dat_q[16])
        ovf_q <= 1'b0;

      if (flush) begin
        wr_q    <= '0;
        rd_q    <= '0;
        count_q <= '0;
        we_q    <= 1'b0;
      end else begin
        count_q <= count_d;
        if (push)
          wr_q <= wr_q + PW'(1);
        if (pop) begin
          wdata_q <= mem_q[rd_q];
          rd_q    <= rd_q + PW'(1);
          we_q    <= 1'b1;
        end else if (handshake) begin
          we_q <= 1'b0;
        end
      end
    end
  end

  // FIFO storage. It has no reset, so it can map to RAM. The read is registered into wdata_q.
  always_ff @(posedge wb_clk_i) begin
    if (push)
      mem_q[wr_q] <= req_dat_q;
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign core_rst_o    = hold_q;
  assign imem_we_o     = we_q;
  assign imem_addr_o   = ptr_q;
  assign imem_wdata_o  = wdata_q;

  // Byte selects and the byte offset do not affect full-word accesses.
  assign unused_bits = ^{wbs.wbs_sel_i, wbs.wbs_adr_i[1:0]};

endmodule
